// File: rtl/gate_probe_pkg.sv
// Shared constants for the gate function prober: decoded function codes
// and the prober FSM state encoding.
package gate_probe_pkg;

  // Function codes reported by the decoder
  localparam logic [3:0] FC_OTHER  = 4'd0;
  localparam logic [3:0] FC_AND    = 4'd1;
  localparam logic [3:0] FC_OR     = 4'd2;
  localparam logic [3:0] FC_XOR    = 4'd3;
  localparam logic [3:0] FC_XNOR   = 4'd4;
  localparam logic [3:0] FC_NAND   = 4'd5;
  localparam logic [3:0] FC_NOR    = 4'd6;
  localparam logic [3:0] FC_NOT_A  = 4'd7;
  localparam logic [3:0] FC_NOT_B  = 4'd8;
  localparam logic [3:0] FC_BUF_A  = 4'd9;
  localparam logic [3:0] FC_BUF_B  = 4'd10;
  localparam logic [3:0] FC_CONST0 = 4'd11;
  localparam logic [3:0] FC_CONST1 = 4'd12;

  // Prober FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/gate_function_prober_if.sv
// Bundle of the prober's control, probe and result signals.
//
// Handshake: start is a request level, sampled only while the prober is
// idle; busy rises the cycle after a start is accepted and stays high through
// the done cycle; done is a single-cycle pulse in the cycle the result
// registers (truth_table, func_code, unstable) first show the new run.
// A start seen while busy is ignored, so a new run needs start high again
// once busy has dropped.
interface gate_function_prober_if;
  logic       start;
  logic       probe_a;
  logic       probe_b;
  logic       probe_y;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic [3:0] func_code;
  logic       unstable;
  logic [1:0] state;  // FSM state, for debug and checkers

  modport master (
    output start, probe_y,
    input  probe_a, probe_b, busy, done, truth_table, func_code, unstable, state
  );

  modport slave (
    input  start, probe_y,
    output probe_a, probe_b, busy, done, truth_table, func_code, unstable, state
  );
endinterface

// File: rtl/gate_func_decoder.sv
// Combinational decode of a 2-input truth table (bit i = y at {a,b}=i)
// into a function code.
module gate_func_decoder
  import gate_probe_pkg::*;
(
  input  logic [3:0] tt,
  output logic [3:0] code
);

  // Map each recognised truth table to its code, everything else is OTHER
  always_comb begin
    code = FC_OTHER;
    case (tt)
      4'b1000: code = FC_AND;
      4'b1110: code = FC_OR;
      4'b0110: code = FC_XOR;
      4'b1001: code = FC_XNOR;
      4'b0111: code = FC_NAND;
      4'b0001: code = FC_NOR;
      4'b0011: code = FC_NOT_A;
      4'b0101: code = FC_NOT_B;
      4'b1100: code = FC_BUF_A;
      4'b1010: code = FC_BUF_B;
      4'b0000: code = FC_CONST0;
      4'b1111: code = FC_CONST1;
      default: code = FC_OTHER;
    endcase
  end

endmodule

// File: rtl/gate_function_prober.sv
// Drives a 2-input combinational device through all four input
// combinations, holds each for SETTLE_CYCLES, samples its output at the end
// of each hold, and reports the truth table, decoded function and a flag for
// outputs that were still moving at the end of a hold.
module gate_function_prober
  import gate_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_function_prober_if.slave  pif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [2:0]    scratch;       // samples of combinations 0..2
  logic          scr_unstable;
  logic          y_prev;
  logic          last_cyc;
  logic          y_glitch;
  logic [3:0]    tt_next;
  logic [3:0]    code_next;

  assign last_cyc = (cnt == LAST);

  // A single-cycle hold has no previous sample of the same combination.
  assign y_glitch = (SETTLE_CYCLES > 1) ? (last_cyc && (pif.probe_y != y_prev)) : 1'b0;

  // Combination 3 is sampled on the same edge that loads the results.
  assign tt_next = {pif.probe_y, scratch};

  assign pif.state = state;

  gate_func_decoder u_decoder (
    .tt   (tt_next),
    .code (code_next)
  );

  // Previous-cycle copy of the device output for the stability check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_prev <= 1'b0;
    end else begin
      y_prev <= pif.probe_y;
    end
  end

  // Probe sequencing FSM, scratch table and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      idx             <= 2'd0;
      cnt             <= '0;
      scratch         <= 3'd0;
      scr_unstable    <= 1'b0;
      pif.probe_a     <= 1'b0;
      pif.probe_b     <= 1'b0;
      pif.busy        <= 1'b0;
      pif.done        <= 1'b0;
      pif.truth_table <= 4'd0;
      pif.func_code   <= 4'd0;
      pif.unstable    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pif.start) begin
            state        <= ST_DRIVE;
            idx          <= 2'd0;
            cnt          <= '0;
            scratch      <= 3'd0;
            scr_unstable <= 1'b0;
            pif.probe_a  <= 1'b0;
            pif.probe_b  <= 1'b0;
            pif.busy     <= 1'b1;
          end
        end

        ST_DRIVE: begin
          if (y_glitch) begin
            scr_unstable <= 1'b1;
          end
          if (last_cyc) begin
            cnt <= '0;
            if (idx != 2'd3) begin
              scratch <= scratch | (3'(pif.probe_y) << idx);
              idx     <= idx + 2'd1;
              {pif.probe_a, pif.probe_b} <= idx + 2'd1;
            end else begin
              state           <= ST_DONE;
              pif.probe_a     <= 1'b0;
              pif.probe_b     <= 1'b0;
              pif.done        <= 1'b1;
              pif.truth_table <= tt_next;
              pif.func_code   <= code_next;
              pif.unstable    <= scr_unstable | y_glitch;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          pif.done <= 1'b0;
          pif.busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_function_prober.sv
// Bench for gate_function_prober: three probers (settle 1, 2, 3) each
// connected to a small NAND-built device selected by mode. A cycle-indexed
// model predicts every output each cycle; directed runs add literal checks.
module tb_gate_function_prober;
  import gate_probe_pkg::*;

  localparam int N = 3;  // instance i uses SETTLE_CYCLES = i+1

  localparam int M_AND  = 0;
  localparam int M_XOR  = 1;
  localparam int M_XNOR = 2;
  localparam int M_ONE  = 3;
  localparam int M_ANB  = 4;
  localparam int M_OR   = 5;
  localparam int M_TOG  = 6;  // OR-like, but toggles every cycle at {a,b}=2

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tog = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  logic       start_v [N];
  int         mode_v  [N];
  logic       o_pa    [N];
  logic       o_pb    [N];
  logic       o_busy  [N];
  logic       o_done  [N];
  logic [3:0] o_tt    [N];
  logic [3:0] o_fc    [N];
  logic       o_un    [N];

  int checks = 0;
  int errors = 0;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // Device under probe, built from NAND gates where it is a real gate
  function automatic logic dev_y(input int m, input logic a, input logic b, input logic t);
    logic n;
    logic x;
    n = nand2(a, b);
    x = nand2(nand2(a, n), nand2(b, n));
    case (m)
      M_AND:  return nand2(n, n);
      M_XOR:  return x;
      M_XNOR: return nand2(x, x);
      M_ONE:  return 1'b1;
      M_ANB:  return a & ~b;
      M_OR:   return nand2(nand2(a, a), nand2(b, b));
      M_TOG:  return (a && !b) ? t : (a | b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] expect_code(input logic [3:0] t);
    case (t)
      4'b1000: return 4'd1;
      4'b1110: return 4'd2;
      4'b0110: return 4'd3;
      4'b1001: return 4'd4;
      4'b0111: return 4'd5;
      4'b0001: return 4'd6;
      4'b0011: return 4'd7;
      4'b0101: return 4'd8;
      4'b1100: return 4'd9;
      4'b1010: return 4'd10;
      4'b0000: return 4'd11;
      4'b1111: return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT instances ----------------
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : u
      gate_function_prober_if pif ();
      assign pif.start   = start_v[g];
      assign pif.probe_y = dev_y(mode_v[g], pif.probe_a, pif.probe_b, tog);
      assign o_pa[g]   = pif.probe_a;
      assign o_pb[g]   = pif.probe_b;
      assign o_busy[g] = pif.busy;
      assign o_done[g] = pif.done;
      assign o_tt[g]   = pif.truth_table;
      assign o_fc[g]   = pif.func_code;
      assign o_un[g]   = pif.unstable;

      gate_function_prober #(.SETTLE_CYCLES(g + 1)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif.slave)
      );
    end
  endgenerate

  // ---------------- model + scoreboard ----------------
  // cyc[i]: 0 when idle, otherwise the cycle number within the run (1..4S+1)
  int         cyc    [N];
  logic [3:0] scr_tt [N];
  logic       scr_un [N];
  logic       prev_y [N];
  logic [3:0] m_tt   [N];
  logic [3:0] m_fc   [N];
  logic       m_un   [N];

  always @(negedge clk) begin
    int s;
    int k;
    logic y;
    logic ea, eb, ebusy, edone;
    for (int i = 0; i < N; i++) begin
      s = i + 1;
      k = 0;
      ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b0;
      if (rst) begin
        cyc[i]  = 0;
        m_tt[i] = 4'd0;
        m_fc[i] = 4'd0;
        m_un[i] = 1'b0;
      end else if (cyc[i] >= 1 && cyc[i] <= 4 * s) begin
        k = (cyc[i] - 1) / s;
        ea = k[1];
        eb = k[0];
        ebusy = 1'b1;
        y = dev_y(mode_v[i], ea, eb, tog);
        if ((cyc[i] - 1) % s == s - 1) begin
          scr_tt[i][k] = y;
          if (s > 1 && y != prev_y[i]) scr_un[i] = 1'b1;
        end
        prev_y[i] = y;
      end else if (cyc[i] == 4 * s + 1) begin
        ebusy = 1'b1;
        edone = 1'b1;
        m_tt[i] = scr_tt[i];
        m_fc[i] = expect_code(scr_tt[i]);
        m_un[i] = scr_un[i];
      end

      chk($sformatf("s%0d probe_a", s), o_pa[i], ea);
      chk($sformatf("s%0d probe_b", s), o_pb[i], eb);
      chk($sformatf("s%0d busy", s), o_busy[i], ebusy);
      chk($sformatf("s%0d done", s), o_done[i], edone);
      chk($sformatf("s%0d truth_table", s), o_tt[i], m_tt[i]);
      chk($sformatf("s%0d func_code", s), o_fc[i], m_fc[i]);
      chk($sformatf("s%0d unstable", s), o_un[i], m_un[i]);

      if (rst) begin
        cyc[i] = 0;
      end else if (cyc[i] == 0) begin
        if (start_v[i]) begin
          cyc[i] = 1;
          scr_tt[i] = 4'd0;
          scr_un[i] = 1'b0;
        end
      end else if (cyc[i] == 4 * s + 1) begin
        cyc[i] = 0;
      end else begin
        cyc[i] = cyc[i] + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; returns just after the edge that ends
  // the done cycle. done_cyc is the cycle (1 = first cycle after acceptance)
  // in which done was seen, 0 if it never came.
  task automatic run_probe(input int i, input int m, output int done_cyc);
    mode_v[i]  = m;
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    done_cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (o_done[i]) begin
        done_cyc = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int dc;
  int pulses;

  initial begin
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = M_AND;
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset busy", o_busy[1], 1'b0);
    chk("reset truth_table", o_tt[1], 4'd0);
    chk("reset func_code", o_fc[1], 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // AND, S=2
    run_probe(1, M_AND, dc);
    chk("and done cycle", dc, 9);
    chk("and truth_table", o_tt[1], 4'b1000);
    chk("and func_code", o_fc[1], 4'd1);
    chk("and unstable", o_un[1], 1'b0);

    // XOR then XNOR back to back, S=2
    run_probe(1, M_XOR, dc);
    chk("xor truth_table", o_tt[1], 4'b0110);
    chk("xor func_code", o_fc[1], 4'd3);
    run_probe(1, M_XNOR, dc);
    chk("xnor done cycle", dc, 9);
    chk("xnor truth_table", o_tt[1], 4'b1001);
    chk("xnor func_code", o_fc[1], 4'd4);

    // constant 1 and a&~b, S=1
    run_probe(0, M_ONE, dc);
    chk("const1 done cycle", dc, 5);
    chk("const1 func_code", o_fc[0], 4'd12);
    run_probe(0, M_ANB, dc);
    chk("a_and_not_b truth_table", o_tt[0], 4'b0100);
    chk("a_and_not_b func_code", o_fc[0], 4'd0);

    // toggling output then clean OR, S=3
    run_probe(2, M_TOG, dc);
    chk("toggle done cycle", dc, 13);
    chk("toggle unstable", o_un[2], 1'b1);
    run_probe(2, M_OR, dc);
    chk("or unstable", o_un[2], 1'b0);
    chk("or func_code", o_fc[2], 4'd2);
    chk("or truth_table", o_tt[2], 4'b1110);

    // reset in cycle 3 of a run, S=2
    mode_v[1]  = M_AND;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun reset busy", o_busy[1], 1'b0);
    chk("midrun reset probe_b", o_pb[1], 1'b0);
    chk("midrun reset truth_table", o_tt[1], 4'd0);
    chk("midrun reset func_code", o_fc[1], 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done[1]) pulses++;
    end
    chk("midrun reset done pulses", pulses, 0);
    @(posedge clk); #1;
    run_probe(1, M_AND, dc);
    chk("rerun done cycle", dc, 9);
    chk("rerun func_code", o_fc[1], 4'd1);

    // start held for 20 cycles, S=2: exactly two runs
    mode_v[1]  = M_OR;
    start_v[1] = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_done[1]) pulses++;
      @(posedge clk); #1;
    end
    start_v[1] = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (o_done[1]) pulses++;
    end
    chk("held start done pulses", pulses, 2);
    chk("held start busy after", o_busy[1], 1'b0);
    chk("held start func_code", o_fc[1], 4'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
